// File: rtl/gfb_pkg.sv
// Shared GFB definitions: the command encodings used by the GFB master and
// slave, the command arbiter's state encoding, and operand widths.
package gfb_pkg;

    localparam int GFB_AW = 10;
    localparam int GFB_DW = 10;
    localparam int GFB_CW = 10;

    typedef enum logic [2:0] {
        GFB_IDLE       = 3'd0,
        GFB_READ       = 3'd1,
        GFB_WRITE      = 3'd2,
        GFB_ROW_WRITE  = 3'd3,
        GFB_ERASE      = 3'd4,
        GFB_MASS_ERASE = 3'd5
    } gfb_cmd_e;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_LOW  = 3'd2,
        S_WAIT_HIGH = 3'd3,
        S_RESP      = 3'd4
    } arb_state_e;

    // Only READ..MASS_ERASE are sent to the master; anything else is
    // answered locally.
    function automatic logic cmd_is_valid(input logic [2:0] cmd);
        return (cmd != 3'(GFB_IDLE)) && (cmd <= 3'(GFB_MASS_ERASE));
    endfunction

endpackage

// File: rtl/gfb_rr_arb2.sv
// Two-way round-robin grant.
//   PCLK, RESET_pclk : clock, synchronous active-high reset
//   req[1:0]         : pending requests
//   ptr_update       : pulse when the granted command has completed
//   last_gnt         : requester that was just served
//   gnt_valid        : some request is pending
//   gnt_idx          : requester to grant this cycle
module gfb_rr_arb2 (
    input  logic       PCLK,
    input  logic       RESET_pclk,
    input  logic [1:0] req,
    input  logic       ptr_update,
    input  logic       last_gnt,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    logic ptr_q;

    always_ff @(posedge PCLK) begin
        if (RESET_pclk) begin
            ptr_q <= 1'b0;
        end else if (ptr_update) begin
            ptr_q <= ~last_gnt;
        end
    end

    // The pointer only decides ties; a lone request always wins.
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = ptr_q;
        if (req == 2'b01) begin
            gnt_idx = 1'b0;
        end else if (req == 2'b10) begin
            gnt_idx = 1'b1;
        end
    end

endmodule

// File: rtl/gfb_cmd_arbiter.sv
// Arbitrates two command requesters onto a single GFB master, one command
// in flight at a time, with a wait timeout and per-command abort.
//   PCLK, RESET_pclk                 : clock, synchronous active-high reset
//   reqN_valid/cmd/addr/wdata/abort  : requester N command inputs
//   reqN_accept                      : pulse, command latched
//   reqN_done/rdata/resp             : pulse with completion data
//   CMD/ADDR/WDATA/ABORT             : to the GFB master
//   READY_pclk/RDATA_pclk/RESP_pclk  : from the GFB master
//   timeout_err                      : pulse when the master wait expires
//
// state       | meaning
// S_IDLE      | waiting for READY and a pending request
// S_ISSUE     | command latched; present it or answer it locally
// S_WAIT_LOW  | waiting for the master to drop READY
// S_WAIT_HIGH | waiting for READY to return with the result
// S_RESP      | done pulse to the granted requester
module gfb_cmd_arbiter
    import gfb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        PCLK,
    input  logic        RESET_pclk,
    input  logic        req0_valid,
    input  logic [2:0]  req0_cmd,
    input  logic [9:0]  req0_addr,
    input  logic [9:0]  req0_wdata,
    input  logic        req0_abort,
    output logic        req0_accept,
    output logic        req0_done,
    output logic [9:0]  req0_rdata,
    output logic        req0_resp,
    input  logic        req1_valid,
    input  logic [2:0]  req1_cmd,
    input  logic [9:0]  req1_addr,
    input  logic [9:0]  req1_wdata,
    input  logic        req1_abort,
    output logic        req1_accept,
    output logic        req1_done,
    output logic [9:0]  req1_rdata,
    output logic        req1_resp,
    output logic [2:0]  CMD,
    output logic [9:0]  ADDR,
    output logic [9:0]  WDATA,
    output logic        ABORT,
    input  logic        READY_pclk,
    input  logic [9:0]  RDATA_pclk,
    input  logic        RESP_pclk,
    output logic        timeout_err
);

    localparam logic [GFB_CW-1:0] TMO = GFB_CW'(TIMEOUT_CYCLES);

    arb_state_e        state_q, state_d;
    logic              grant_q;
    logic [2:0]        cmd_q;
    logic [GFB_AW-1:0] addr_q;
    logic [GFB_DW-1:0] wdata_q;
    logic [GFB_CW-1:0] cnt_q, cnt_inc;
    logic              abort_used_q;
    logic [GFB_DW-1:0] rsp_rdata_q;
    logic              rsp_resp_q;
    logic [1:0]        accept_q;
    logic [2:0]        cmd_out_q;
    logic [GFB_AW-1:0] addr_out_q;
    logic [GFB_DW-1:0] wdata_out_q;
    logic              abort_out_q;
    logic              tmo_q;

    logic gnt_valid, gnt_idx, ptr_update;
    logic in_wait, own_abort, tmo_hit;
    logic do_grant, do_issue, do_skip, do_capture, do_timeout, do_abort;

    gfb_rr_arb2 u_rr (
        .PCLK       (PCLK),
        .RESET_pclk (RESET_pclk),
        .req        ({req1_valid, req0_valid}),
        .ptr_update (ptr_update),
        .last_gnt   (grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    assign cnt_inc   = cnt_q + GFB_CW'(1);
    assign in_wait   = (state_q == S_WAIT_LOW) || (state_q == S_WAIT_HIGH);
    assign own_abort = grant_q ? req1_abort : req0_abort;
    // Fires on the wait cycle whose increment reaches the limit.
    assign tmo_hit   = (cnt_q == TMO) || (cnt_inc == TMO);

    always_ff @(posedge PCLK) begin
        if (RESET_pclk) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        do_grant   = 1'b0;
        do_issue   = 1'b0;
        do_skip    = 1'b0;
        do_capture = 1'b0;
        do_timeout = 1'b0;
        ptr_update = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (READY_pclk && gnt_valid) begin
                    do_grant = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cmd_is_valid(cmd_q)) begin
                    do_issue = 1'b1;
                    state_d  = S_WAIT_LOW;
                end else begin
                    do_skip = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_WAIT_LOW: begin
                if (tmo_hit) begin
                    do_timeout = 1'b1;
                    state_d    = S_RESP;
                end else if (!READY_pclk) begin
                    state_d = S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                // A completion on the last wait cycle beats the timeout.
                if (READY_pclk) begin
                    do_capture = 1'b1;
                    state_d    = S_RESP;
                end else if (tmo_hit) begin
                    do_timeout = 1'b1;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                ptr_update = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        do_abort = in_wait && own_abort && !abort_used_q && !do_timeout && !do_capture;
    end

    always_ff @(posedge PCLK) begin
        if (RESET_pclk) begin
            grant_q      <= 1'b0;
            cmd_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            abort_used_q <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_resp_q   <= 1'b0;
            accept_q     <= '0;
            cmd_out_q    <= '0;
            addr_out_q   <= '0;
            wdata_out_q  <= '0;
            abort_out_q  <= 1'b0;
            tmo_q        <= 1'b0;
        end else begin
            accept_q    <= '0;
            cmd_out_q   <= '0;
            abort_out_q <= 1'b0;
            tmo_q       <= 1'b0;
            if (do_grant) begin
                grant_q  <= gnt_idx;
                cmd_q    <= gnt_idx ? req1_cmd   : req0_cmd;
                addr_q   <= gnt_idx ? req1_addr  : req0_addr;
                wdata_q  <= gnt_idx ? req1_wdata : req0_wdata;
                accept_q <= gnt_idx ? 2'b10 : 2'b01;
            end
            if (do_issue) begin
                cmd_out_q    <= cmd_q;
                addr_out_q   <= addr_q;
                wdata_out_q  <= wdata_q;
                cnt_q        <= '0;
                abort_used_q <= 1'b0;
            end else if (in_wait && (cnt_q != TMO)) begin
                cnt_q <= cnt_inc;
            end
            if (do_skip || do_timeout) begin
                rsp_rdata_q <= '0;
                rsp_resp_q  <= 1'b1;
            end
            if (do_capture) begin
                rsp_rdata_q <= RDATA_pclk;
                rsp_resp_q  <= RESP_pclk;
            end
            if (do_timeout) begin
                abort_out_q <= 1'b1;
                tmo_q       <= 1'b1;
            end
            if (do_abort) begin
                abort_out_q  <= 1'b1;
                abort_used_q <= 1'b1;
            end
        end
    end

    assign req0_accept = accept_q[0];
    assign req1_accept = accept_q[1];
    assign req0_done   = (state_q == S_RESP) && !grant_q;
    assign req1_done   = (state_q == S_RESP) &&  grant_q;
    assign req0_rdata  = req0_done ? rsp_rdata_q : '0;
    assign req1_rdata  = req1_done ? rsp_rdata_q : '0;
    assign req0_resp   = req0_done && rsp_resp_q;
    assign req1_resp   = req1_done && rsp_resp_q;
    assign CMD         = cmd_out_q;
    assign ADDR        = addr_out_q;
    assign WDATA       = wdata_out_q;
    assign ABORT       = abort_out_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_gfb_cmd_arbiter.sv
module tb_gfb_cmd_arbiter;
    import gfb_pkg::*;

    logic       PCLK = 1'b0;
    logic       RESET_pclk = 1'b1;
    logic       req0_valid = 0, req1_valid = 0;
    logic [2:0] req0_cmd = 0, req1_cmd = 0;
    logic [9:0] req0_addr = 0, req1_addr = 0, req0_wdata = 0, req1_wdata = 0;
    logic       req0_abort = 0, req1_abort = 0;
    logic       req0_accept, req1_accept, req0_done, req1_done, req0_resp, req1_resp;
    logic [9:0] req0_rdata, req1_rdata;
    logic [2:0] CMD;
    logic [9:0] ADDR, WDATA;
    logic       ABORT, timeout_err;
    logic       READY_pclk = 1'b1;
    logic [9:0] RDATA_pclk = 0;
    logic       RESP_pclk = 0;

    always #5 PCLK = ~PCLK;

    gfb_cmd_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .PCLK(PCLK), .RESET_pclk(RESET_pclk),
        .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_abort(req0_abort), .req0_accept(req0_accept),
        .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_resp(req0_resp),
        .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_abort(req1_abort), .req1_accept(req1_accept),
        .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_resp(req1_resp),
        .CMD(CMD), .ADDR(ADDR), .WDATA(WDATA), .ABORT(ABORT),
        .READY_pclk(READY_pclk), .RDATA_pclk(RDATA_pclk), .RESP_pclk(RESP_pclk),
        .timeout_err(timeout_err)
    );

    typedef struct {
        int         id;
        logic [2:0] cmd;
        logic [9:0] addr;
        logic [9:0] wdata;
        logic [9:0] rdata;
        logic       resp;
        int         gap;
        int         lo;
        bit         stuck;
        bit         no_done;
    } txn_t;

    typedef struct {
        int         id;
        logic [9:0] rdata;
        logic       resp;
    } done_t;

    txn_t  plan_q[$];
    int    acc_q[$];
    done_t done_q[$];

    int checks = 0, errors = 0;
    int abort_cnt = 0, tmo_cnt = 0;
    bit mbusy = 0;
    int ptr_m = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event with no expectation at %0t", name, $time);
    endtask

    function automatic txn_t mk(input int id, input logic [2:0] cmd, input logic [9:0] addr,
                                input logic [9:0] wdata, input logic [9:0] rdata, input logic resp,
                                input int gap, input int lo, input bit stuck, input bit no_done);
        txn_t t;
        t.id = id; t.cmd = cmd; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        t.resp = resp; t.gap = gap; t.lo = lo; t.stuck = stuck; t.no_done = no_done;
        return t;
    endfunction

    function automatic txn_t rnd_txn(input int id);
        logic [2:0] c;
        int pick;
        if ($urandom_range(0, 4) == 0) begin
            pick = $urandom_range(0, 2);
            c = (pick == 0) ? 3'd0 : ((pick == 1) ? 3'd6 : 3'd7);
        end else begin
            c = 3'($urandom_range(1, 5));
        end
        return mk(id, c, 10'($urandom), 10'($urandom), 10'($urandom), 1'($urandom),
                  $urandom_range(0, 1), $urandom_range(1, 3), 0, 0);
    endfunction

    // Monitor: accepts and completions against the scoreboard queues.
    int    mon_id;
    int    mon_acc;
    done_t mon_d;
    initial begin
        forever begin
            @(negedge PCLK);
            if (req0_accept || req1_accept) begin
                check("accept_onehot", 64'(req0_accept & req1_accept), 64'(0));
                if (acc_q.size() == 0) fail_evt("unexpected_accept");
                else begin
                    mon_acc = acc_q.pop_front();
                    check("accept_id", 64'(req1_accept ? 1 : 0), 64'(mon_acc));
                end
            end
            if (req0_done || req1_done) begin
                mon_id = req1_done ? 1 : 0;
                if (done_q.size() == 0) fail_evt("unexpected_done");
                else begin
                    mon_d = done_q.pop_front();
                    check("done_id", 64'(mon_id), 64'(mon_d.id));
                    check("done_rdata", 64'(mon_id ? req1_rdata : req0_rdata), 64'(mon_d.rdata));
                    check("done_resp", 64'(mon_id ? req1_resp : req0_resp), 64'(mon_d.resp));
                    check("other_rdata_resp", 64'(mon_id ? {req0_rdata, req0_resp} : {req1_rdata, req1_resp}), 64'(0));
                end
            end
            if (timeout_err) begin
                tmo_cnt++;
                check("timeout_with_abort", 64'(ABORT), 64'(1));
            end
            if (ABORT) abort_cnt++;
        end
    end

    // GFB master model: consumes the issue plan in command order.
    txn_t mp;
    initial begin
        forever begin
            @(negedge PCLK);
            if (CMD != 3'd0) begin
                mbusy = 1;
                if (plan_q.size() == 0) fail_evt("unexpected_cmd");
                else begin
                    mp = plan_q.pop_front();
                    check("cmd", 64'(CMD), 64'(mp.cmd));
                    check("addr", 64'(ADDR), 64'(mp.addr));
                    check("wdata", 64'(WDATA), 64'(mp.wdata));
                    @(negedge PCLK);
                    check("cmd_one_cycle", 64'(CMD), 64'(0));
                    repeat (mp.gap) @(negedge PCLK);
                    READY_pclk = 1'b0;
                    repeat (mp.lo) @(negedge PCLK);
                    RDATA_pclk = mp.rdata;
                    RESP_pclk  = mp.resp;
                    READY_pclk = 1'b1;
                    @(negedge PCLK);
                    if (!mp.stuck && !mp.no_done)
                        check("ready_to_done", 64'(mp.id ? req1_done : req0_done), 64'(1));
                    RDATA_pclk = 10'($urandom);
                    RESP_pclk  = 1'($urandom);
                end
                mbusy = 0;
            end
        end
    end

    function automatic logic [63:0] all_outs();
        return 64'({req0_accept, req1_accept, req0_done, req1_done, req0_rdata, req1_rdata,
                    req0_resp, req1_resp, CMD, ADDR, WDATA, ABORT, timeout_err});
    endfunction

    task automatic run_round(input txn_t t0, input bit v0, input txn_t t1, input bit v1,
                             input int ab_id, input int ab_len, input int rst_at,
                             input int exp_abort, input int exp_tmo);
        int    order[$];
        txn_t  t;
        done_t d;
        int    k, first_acc;
        bit    acc0, acc1;
        if (v0 && v1) begin
            order.push_back(ptr_m);
            order.push_back(1 - ptr_m);
        end else if (v0) order.push_back(0);
        else order.push_back(1);
        foreach (order[j]) begin
            if (order[j] == 1) t = t1; else t = t0;
            acc_q.push_back(t.id);
            if (t.cmd >= 3'd1 && t.cmd <= 3'd5) begin
                plan_q.push_back(t);
                d.id = t.id; d.rdata = t.stuck ? 10'd0 : t.rdata; d.resp = t.stuck ? 1'b1 : t.resp;
            end else begin
                d.id = t.id; d.rdata = 10'd0; d.resp = 1'b1;
            end
            if (!t.no_done) begin
                done_q.push_back(d);
                ptr_m = 1 - t.id;
            end
        end
        @(negedge PCLK);
        abort_cnt = 0;
        tmo_cnt   = 0;
        req0_valid = v0; req0_cmd = t0.cmd; req0_addr = t0.addr; req0_wdata = t0.wdata;
        req1_valid = v1; req1_cmd = t1.cmd; req1_addr = t1.addr; req1_wdata = t1.wdata;
        acc0 = !v0; acc1 = !v1; first_acc = -1; k = 0;
        while (!(acc0 && acc1 && done_q.size() == 0 && plan_q.size() == 0 && !mbusy) && k < 300) begin
            @(negedge PCLK);
            k++;
            if (req0_accept) begin acc0 = 1; req0_valid = 0; if (first_acc < 0) first_acc = k; end
            if (req1_accept) begin acc1 = 1; req1_valid = 0; if (first_acc < 0) first_acc = k; end
            req0_abort = (ab_id == 0) && first_acc > 0 && k >= first_acc + 2 && k < first_acc + 2 + ab_len;
            req1_abort = (ab_id == 1) && first_acc > 0 && k >= first_acc + 2 && k < first_acc + 2 + ab_len;
            if (rst_at > 0 && first_acc > 0 && k == first_acc + rst_at) RESET_pclk = 1'b1;
            if (rst_at > 0 && first_acc > 0 && k == first_acc + rst_at + 2) begin
                check("reset_mid_cmd_outputs", all_outs(), 64'(0));
                RESET_pclk = 1'b0;
                ptr_m = 0;
            end
        end
        req0_abort = 0; req1_abort = 0; req0_valid = 0; req1_valid = 0;
        if (k >= 300) fail_evt("round_timeout");
        check("accept_latency", 64'(first_acc), 64'(1));
        check("abort_count", 64'(abort_cnt), 64'(exp_abort));
        check("timeout_count", 64'(tmo_cnt), 64'(exp_tmo));
    endtask

    txn_t a, b, z;
    initial begin
        z = mk(0, 3'd0, 0, 0, 0, 0, 0, 1, 0, 0);
        repeat (3) @(negedge PCLK);
        check("reset_outputs", all_outs(), 64'(0));
        RESET_pclk = 1'b0;

        a = mk(0, 3'(GFB_WRITE), 10'h005, 10'h155, 10'h0AA, 1'b1, 0, 3, 0, 0);
        run_round(a, 1, z, 0, -1, 0, 0, 0, 0);

        b = mk(1, 3'(GFB_READ), 10'h3FF, 10'h000, 10'h2A5, 1'b0, 0, 2, 0, 0);
        run_round(z, 0, b, 1, -1, 0, 0, 0, 0);

        a = mk(0, 3'(GFB_READ), 10'h011, 10'h022, 10'h133, 1'b0, 1, 2, 0, 0);
        b = mk(1, 3'(GFB_WRITE), 10'h244, 10'h355, 10'h066, 1'b1, 0, 1, 0, 0);
        run_round(a, 1, b, 1, -1, 0, 0, 0, 0);
        a = mk(0, 3'(GFB_ROW_WRITE), 10'h077, 10'h088, 10'h199, 1'b1, 0, 3, 0, 0);
        b = mk(1, 3'(GFB_ERASE), 10'h2AA, 10'h3BB, 10'h0CC, 1'b0, 1, 1, 0, 0);
        run_round(a, 1, b, 1, -1, 0, 0, 0, 0);

        a = mk(0, 3'(GFB_ERASE), 10'h100, 10'h200, 10'h3FF, 1'b0, 0, 20, 1, 0);
        run_round(a, 1, z, 0, -1, 0, 0, 1, 1);

        a = mk(0, 3'(GFB_WRITE), 10'h123, 10'h321, 10'h111, 1'b0, 0, 5, 0, 0);
        run_round(a, 1, z, 0, 0, 3, 0, 1, 0);
        a = mk(0, 3'(GFB_READ), 10'h045, 10'h054, 10'h222, 1'b1, 0, 5, 0, 0);
        run_round(a, 1, z, 0, 1, 4, 0, 0, 0);

        abort_cnt = 0;
        @(negedge PCLK);
        req0_abort = 1; req1_abort = 1;
        repeat (3) @(negedge PCLK);
        req0_abort = 0; req1_abort = 0;
        repeat (2) @(negedge PCLK);
        check("idle_abort_ignored", 64'(abort_cnt), 64'(0));

        a = mk(0, 3'(GFB_IDLE), 10'h0F0, 10'h00F, 10'h3C3, 1'b0, 0, 1, 0, 0);
        run_round(a, 1, z, 0, -1, 0, 0, 0, 0);
        b = mk(1, 3'd7, 10'h1F1, 10'h2E2, 10'h3D3, 1'b0, 0, 1, 0, 0);
        run_round(z, 0, b, 1, -1, 0, 0, 0, 0);

        b = mk(1, 3'(GFB_READ), 10'h155, 10'h0AA, 10'h2B2, 1'b1, 0, 20, 0, 1);
        run_round(z, 0, b, 1, -1, 0, 4, 0, 0);

        for (int r = 0; r < 40; r++) begin
            int m;
            m = $urandom_range(1, 3);
            a = rnd_txn(0);
            b = rnd_txn(1);
            run_round(a, m[0], b, m[1], -1, 0, 0, 0, 0);
        end

        repeat (3) @(negedge PCLK);
        check("accept_queue_drained", 64'(acc_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation did not complete");
        $fatal(1, "time limit");
    end

endmodule
